// File: rtl/decode_pkg.sv
// Shared decode/issue definitions: opcode constants, operand modes, issue FSM states
// and the instruction payload carried from decode to execute.
package decode_pkg;

  localparam int unsigned NUM_REGS  = 16;
  localparam int unsigned REG_IDX_W = 4;
  localparam int unsigned OPC_W     = 8;
  localparam int unsigned MODE_W    = 2;
  localparam int unsigned OPND_W    = 16;

  localparam logic [OPC_W-1:0] OP_NOP  = 8'h00;
  localparam logic [OPC_W-1:0] OP_HALT = 8'hFF;

  typedef enum logic [MODE_W-1:0] {
    IMM     = 2'd0,
    REG     = 2'd1,
    MEM     = 2'd2,
    REG_IND = 2'd3
  } mode_t;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    STALL  = 2'd1,
    DRAIN  = 2'd2,
    HALTED = 2'd3
  } issue_state_t;

  typedef struct packed {
    logic [OPC_W-1:0]  opcode;
    logic [MODE_W-1:0] mode1;
    logic [OPND_W-1:0] op1;
    logic [MODE_W-1:0] mode2;
    logic [OPND_W-1:0] op2;
  } issue_payload_t;

  // Register and register-indirect operands both read the register file.
  function automatic logic mode_reads_reg(input logic [MODE_W-1:0] mode);
    return (mode_t'(mode) == REG) || (mode_t'(mode) == REG_IND);
  endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// Register scoreboard: one pending bit per architectural register, set on issue of a
// writer, cleared on writeback or flush, with a combinational hazard lookup.
module reg_scoreboard
  import decode_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush_i,
  input  logic                 set_en_i,
  input  logic [REG_IDX_W-1:0] set_idx_i,
  input  logic                 clr_en_i,
  input  logic [REG_IDX_W-1:0] clr_idx_i,
  input  logic                 src1_en_i,
  input  logic [REG_IDX_W-1:0] src1_idx_i,
  input  logic                 src2_en_i,
  input  logic [REG_IDX_W-1:0] src2_idx_i,
  input  logic                 dst_en_i,
  input  logic [REG_IDX_W-1:0] dst_idx_i,
  output logic                 hazard_c,
  output logic [NUM_REGS-1:0]  busy_o
);

  logic [NUM_REGS-1:0] busy_q;
  logic [NUM_REGS-1:0] busy_d;

  // Clear before set so an issue and a retire of the same register leave it busy.
  always_comb begin
    busy_d = busy_q;
    if (clr_en_i) busy_d[clr_idx_i] = 1'b0;
    if (set_en_i) busy_d[set_idx_i] = 1'b1;
    if (flush_i)  busy_d = '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) busy_q <= '0;
    else        busy_q <= busy_d;
  end

  // Lookup uses only the registered bits: a same-cycle writeback does not unblock.
  assign hazard_c = (src1_en_i & busy_q[src1_idx_i])
                  | (src2_en_i & busy_q[src2_idx_i])
                  | (dst_en_i  & busy_q[dst_idx_i]);

  assign busy_o = busy_q;

endmodule

// File: rtl/issue_controller.sv
// Decode-to-execute issue stage with scoreboard hazard stalls, NOP bypass, HALT drain
// and flush. Optional ISSUE_STATS_EN adds stall_cycles / issued_count counters.
module issue_controller
  import decode_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 dec_valid,
  output logic                 dec_ready,
  input  logic [OPC_W-1:0]     dec_opcode,
  input  logic [MODE_W-1:0]    dec_mode1,
  input  logic [OPND_W-1:0]    dec_op1,
  input  logic [MODE_W-1:0]    dec_mode2,
  input  logic [OPND_W-1:0]    dec_op2,
  input  logic                 dec_wr_en,
  output logic                 ex_valid,
  input  logic                 ex_ready,
  output logic [OPC_W-1:0]     ex_opcode,
  output logic [MODE_W-1:0]    ex_mode1,
  output logic [OPND_W-1:0]    ex_op1,
  output logic [MODE_W-1:0]    ex_mode2,
  output logic [OPND_W-1:0]    ex_op2,
  input  logic                 wb_valid,
  input  logic [REG_IDX_W-1:0] wb_reg,
  input  logic                 flush,
  output logic                 halted,
`ifdef ISSUE_STATS_EN
  output logic [31:0]          stall_cycles,
  output logic [31:0]          issued_count,
`endif
  output logic [NUM_REGS-1:0]  busy_regs
);

  issue_state_t   state_q, state_d;
  logic           ex_valid_q, ex_valid_d;
  issue_payload_t ex_pay_q, ex_pay_d;

  logic is_nop, is_halt, dst_en, src1_en, src2_en;
  logic hazard_raw, hazard, accept, can_issue, sb_set_en;
  logic [REG_IDX_W-1:0] op1_idx, op2_idx;

  assign is_nop  = (dec_opcode == OP_NOP);
  assign is_halt = (dec_opcode == OP_HALT);
  assign op1_idx = dec_op1[REG_IDX_W-1:0];
  assign op2_idx = dec_op2[REG_IDX_W-1:0];
  assign src1_en = !is_nop && mode_reads_reg(dec_mode1);
  assign src2_en = !is_nop && mode_reads_reg(dec_mode2);
  assign dst_en  = !is_nop && dec_wr_en && (mode_t'(dec_mode1) == REG);

  reg_scoreboard u_sb (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush_i    (flush),
    .set_en_i   (sb_set_en),
    .set_idx_i  (op1_idx),
    .clr_en_i   (wb_valid && !flush),
    .clr_idx_i  (wb_reg),
    .src1_en_i  (src1_en),
    .src1_idx_i (op1_idx),
    .src2_en_i  (src2_en),
    .src2_idx_i (op2_idx),
    .dst_en_i   (dst_en),
    .dst_idx_i  (op1_idx),
    .hazard_c   (hazard_raw),
    .busy_o     (busy_regs)
  );

  assign hazard    = hazard_raw;
  assign can_issue = ((state_q == RUN) || (state_q == STALL)) && (!ex_valid_q || ex_ready);
  assign dec_ready = rst_n && can_issue && !hazard && !flush;
  assign accept    = dec_valid && dec_ready;
  // HALT is consumed here and never owns a destination.
  assign sb_set_en = accept && !is_halt && dst_en;

  // Next-state and output-register logic.
  always_comb begin
    state_d    = state_q;
    ex_valid_d = ex_valid_q;
    ex_pay_d   = ex_pay_q;

    if (ex_valid_q && ex_ready) ex_valid_d = 1'b0;
    if (accept && !is_halt) begin
      ex_valid_d      = 1'b1;
      ex_pay_d.opcode = dec_opcode;
      ex_pay_d.mode1  = dec_mode1;
      ex_pay_d.op1    = dec_op1;
      ex_pay_d.mode2  = dec_mode2;
      ex_pay_d.op2    = dec_op2;
    end

    unique case (state_q)
      RUN: begin
        if (accept && is_halt)        state_d = DRAIN;
        else if (dec_valid && hazard) state_d = STALL;
      end
      STALL: begin
        if (accept && is_halt)           state_d = DRAIN;
        else if (!(dec_valid && hazard)) state_d = RUN;
      end
      DRAIN: begin
        if ((busy_regs == '0) && !ex_valid_q) state_d = HALTED;
      end
      HALTED: state_d = HALTED;
      default: state_d = RUN;
    endcase

    if (flush) begin
      state_d    = RUN;
      ex_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= RUN;
      ex_valid_q <= 1'b0;
      ex_pay_q   <= '0;
    end else begin
      state_q    <= state_d;
      ex_valid_q <= ex_valid_d;
      ex_pay_q   <= ex_pay_d;
    end
  end

  assign ex_valid  = ex_valid_q;
  assign ex_opcode = ex_pay_q.opcode;
  assign ex_mode1  = ex_pay_q.mode1;
  assign ex_op1    = ex_pay_q.op1;
  assign ex_mode2  = ex_pay_q.mode2;
  assign ex_op2    = ex_pay_q.op2;
  assign halted    = (state_q == HALTED);

`ifdef ISSUE_STATS_EN
  logic [31:0] stall_q, issued_q;

  // Saturating counters; flush leaves them untouched.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_q  <= '0;
      issued_q <= '0;
    end else begin
      if (dec_valid && !dec_ready && ((state_q == RUN) || (state_q == STALL)) && (stall_q != '1))
        stall_q <= stall_q + 32'd1;
      if (accept && (issued_q != '1))
        issued_q <= issued_q + 32'd1;
    end
  end

  assign stall_cycles = stall_q;
  assign issued_count = issued_q;
`endif

endmodule

// File: tb/tb_issue_controller.sv
// Self-checking bench for issue_controller: directed scenarios with constant expectations
// plus a randomized run against a behavioural scoreboard/pipeline model.
module tb_issue_controller;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        dec_valid, dec_ready;
  logic [7:0]  dec_opcode;
  logic [1:0]  dec_mode1, dec_mode2;
  logic [15:0] dec_op1, dec_op2;
  logic        dec_wr_en;
  logic        ex_valid, ex_ready;
  logic [7:0]  ex_opcode;
  logic [1:0]  ex_mode1, ex_mode2;
  logic [15:0] ex_op1, ex_op2;
  logic        wb_valid;
  logic [3:0]  wb_reg;
  logic        flush, halted;
  logic [15:0] busy_regs;
`ifdef ISSUE_STATS_EN
  logic [31:0] stall_cycles, issued_count;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  issue_controller dut (
    .clk(clk), .rst_n(rst_n),
    .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_opcode(dec_opcode),
    .dec_mode1(dec_mode1), .dec_op1(dec_op1), .dec_mode2(dec_mode2), .dec_op2(dec_op2),
    .dec_wr_en(dec_wr_en),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_opcode(ex_opcode),
    .ex_mode1(ex_mode1), .ex_op1(ex_op1), .ex_mode2(ex_mode2), .ex_op2(ex_op2),
    .wb_valid(wb_valid), .wb_reg(wb_reg), .flush(flush), .halted(halted),
`ifdef ISSUE_STATS_EN
    .stall_cycles(stall_cycles), .issued_count(issued_count),
`endif
    .busy_regs(busy_regs)
  );

  // ---------------- behavioural model ----------------
  bit          m_busy [16];
  bit          m_exv, m_draining, m_halted;
  logic [7:0]  m_opc;
  logic [1:0]  m_m1, m_m2;
  logic [15:0] m_o1, m_o2;

  function automatic bit reads(input logic [1:0] m);
    return (m == 2'd1) || (m == 2'd3);
  endfunction

  function automatic bit m_hazard();
    int r1 = int'(dec_op1[3:0]);
    int r2 = int'(dec_op2[3:0]);
    if (dec_opcode == 8'h00) return 1'b0;
    if (reads(dec_mode1) && m_busy[r1]) return 1'b1;
    if (reads(dec_mode2) && m_busy[r2]) return 1'b1;
    if (dec_wr_en && dec_mode1 == 2'd1 && m_busy[r1]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit m_ready();
    if (flush || m_draining || m_halted) return 1'b0;
    if (m_exv && !ex_ready) return 1'b0;
    return !m_hazard();
  endfunction

  function automatic logic [15:0] m_busy_vec();
    logic [15:0] v = '0;
    for (int i = 0; i < 16; i++) v[i] = m_busy[i];
    return v;
  endfunction

  function automatic void m_reset();
    for (int i = 0; i < 16; i++) m_busy[i] = 1'b0;
    m_exv = 0; m_draining = 0; m_halted = 0;
  endfunction

  // Advance the model by one clock using the inputs currently applied.
  function automatic void m_step();
    bit acc, all_idle;
    if (flush) begin
      m_reset();
      return;
    end
    acc      = dec_valid && m_ready();
    all_idle = (m_busy_vec() == 16'h0) && !m_exv;
    if (wb_valid) m_busy[int'(wb_reg)] = 1'b0;
    if (acc && dec_opcode != 8'h00 && dec_opcode != 8'hFF && dec_wr_en && dec_mode1 == 2'd1)
      m_busy[int'(dec_op1[3:0])] = 1'b1;
    if (m_exv && ex_ready) m_exv = 0;
    if (acc && dec_opcode != 8'hFF) begin
      m_exv = 1; m_opc = dec_opcode; m_m1 = dec_mode1; m_o1 = dec_op1;
      m_m2 = dec_mode2; m_o2 = dec_op2;
    end
    if (m_draining && all_idle) begin
      m_draining = 0; m_halted = 1;
    end else if (acc && dec_opcode == 8'hFF) begin
      m_draining = 1;
    end
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_dec(input logic v, input logic [7:0] opc, input logic [1:0] m1,
                         input logic [15:0] o1, input logic [1:0] m2, input logic [15:0] o2,
                         input logic we);
    dec_valid = v; dec_opcode = opc; dec_mode1 = m1; dec_op1 = o1;
    dec_mode2 = m2; dec_op2 = o2; dec_wr_en = we;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b0; ex_ready = 1'b1; wb_valid = 1'b0; wb_reg = '0; flush = 1'b0;
    set_dec(1'b1, 8'h10, 2'd1, 16'd5, 2'd0, 16'd0, 1'b1);
    repeat (3) tick();
    n_tests++; if (ex_valid !== 1'b0) begin n_fail++; $display("FAIL reset_ex_valid got=%0b exp=0", ex_valid); end
    n_tests++; if (busy_regs !== 16'h0) begin n_fail++; $display("FAIL reset_busy got=%h exp=0000", busy_regs); end
    n_tests++; if (dec_ready !== 1'b0) begin n_fail++; $display("FAIL reset_dec_ready got=%0b exp=0", dec_ready); end
    n_tests++; if (halted !== 1'b0) begin n_fail++; $display("FAIL reset_halted got=%0b exp=0", halted); end
    set_dec(1'b0, 8'h00, 2'd0, 16'd0, 2'd0, 16'd0, 1'b0);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_raw_stall();
    set_dec(1'b1, 8'h10, 2'd1, 16'd5, 2'd0, 16'd0, 1'b1);
    #1;
    n_tests++; if (dec_ready !== 1'b1) begin n_fail++; $display("FAIL raw_writer_ready got=%0b exp=1", dec_ready); end
    tick();
    n_tests++; if (busy_regs !== 16'h0020) begin n_fail++; $display("FAIL raw_busy5 got=%h exp=0020", busy_regs); end
    n_tests++; if (ex_valid !== 1'b1 || ex_opcode !== 8'h10) begin n_fail++; $display("FAIL raw_issue1 got=%0b/%h exp=1/10", ex_valid, ex_opcode); end
    set_dec(1'b1, 8'h11, 2'd0, 16'd0, 2'd1, 16'd5, 1'b0);
    for (int i = 0; i < 3; i++) begin
      #1;
      n_tests++; if (dec_ready !== 1'b0) begin n_fail++; $display("FAIL raw_stall_ready cyc=%0d got=%0b exp=0", i, dec_ready); end
      tick();
    end
    wb_valid = 1'b1; wb_reg = 4'd5;
    #1;
    n_tests++; if (dec_ready !== 1'b0) begin n_fail++; $display("FAIL raw_no_bypass got=%0b exp=0", dec_ready); end
    tick();
    wb_valid = 1'b0;
    #1;
    n_tests++; if (dec_ready !== 1'b1) begin n_fail++; $display("FAIL raw_resume_ready got=%0b exp=1", dec_ready); end
    tick();
    n_tests++; if (ex_valid !== 1'b1 || ex_opcode !== 8'h11 || ex_op2 !== 16'd5)
      begin n_fail++; $display("FAIL raw_issue2 got=%0b/%h/%h exp=1/11/0005", ex_valid, ex_opcode, ex_op2); end
    set_dec(1'b0, 8'h00, 2'd0, 16'd0, 2'd0, 16'd0, 1'b0);
    tick();
  endtask

  task automatic test_backpressure();
    ex_ready = 1'b0;
    set_dec(1'b1, 8'h20, 2'd0, 16'h1234, 2'd2, 16'hBEEF, 1'b0);
    tick();
    set_dec(1'b1, 8'h21, 2'd0, 16'h0001, 2'd0, 16'h0002, 1'b0);
    for (int i = 0; i < 3; i++) begin
      #1;
      n_tests++; if (dec_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready cyc=%0d got=%0b exp=0", i, dec_ready); end
      n_tests++; if (ex_valid !== 1'b1 || ex_opcode !== 8'h20 || ex_op1 !== 16'h1234 || ex_op2 !== 16'hBEEF || ex_mode2 !== 2'd2)
        begin n_fail++; $display("FAIL bp_hold cyc=%0d got=%0b/%h/%h/%h exp=1/20/1234/beef", i, ex_valid, ex_opcode, ex_op1, ex_op2); end
      tick();
    end
    ex_ready = 1'b1;
    #1;
    n_tests++; if (dec_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release_ready got=%0b exp=1", dec_ready); end
    tick();
    n_tests++; if (ex_valid !== 1'b1 || ex_opcode !== 8'h21) begin n_fail++; $display("FAIL bp_next got=%0b/%h exp=1/21", ex_valid, ex_opcode); end
    set_dec(1'b0, 8'h00, 2'd0, 16'd0, 2'd0, 16'd0, 1'b0);
    tick();
    n_tests++; if (ex_valid !== 1'b0) begin n_fail++; $display("FAIL bp_drain got=%0b exp=0", ex_valid); end
  endtask

  task automatic test_same_cycle();
    set_dec(1'b1, 8'h30, 2'd1, 16'd3, 2'd0, 16'd0, 1'b1);
    wb_valid = 1'b1; wb_reg = 4'd3;
    #1;
    n_tests++; if (dec_ready !== 1'b1) begin n_fail++; $display("FAIL sc_ready got=%0b exp=1", dec_ready); end
    tick();
    set_dec(1'b0, 8'h00, 2'd0, 16'd0, 2'd0, 16'd0, 1'b0);
    wb_valid = 1'b0;
    n_tests++; if (busy_regs !== 16'h0008) begin n_fail++; $display("FAIL sc_set_wins got=%h exp=0008", busy_regs); end
    wb_valid = 1'b1; wb_reg = 4'd3;
    tick();
    wb_valid = 1'b0;
    n_tests++; if (busy_regs !== 16'h0000) begin n_fail++; $display("FAIL sc_clear got=%h exp=0000", busy_regs); end
  endtask

  task automatic test_halt_drain();
    set_dec(1'b1, 8'h40, 2'd1, 16'd2, 2'd0, 16'd0, 1'b1);
    tick();
    set_dec(1'b1, 8'hFF, 2'd0, 16'd0, 2'd0, 16'd0, 1'b0);
    #1;
    n_tests++; if (dec_ready !== 1'b1) begin n_fail++; $display("FAIL halt_accept got=%0b exp=1", dec_ready); end
    tick();
    set_dec(1'b1, 8'h41, 2'd0, 16'd0, 2'd0, 16'd0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      #1;
      n_tests++; if (ex_valid !== 1'b0 || halted !== 1'b0 || dec_ready !== 1'b0 || busy_regs !== 16'h0004)
        begin n_fail++; $display("FAIL halt_drain cyc=%0d got=%0b/%0b/%0b/%h exp=0/0/0/0004", i, ex_valid, halted, dec_ready, busy_regs); end
      tick();
    end
    wb_valid = 1'b1; wb_reg = 4'd2;
    tick();
    wb_valid = 1'b0;
    n_tests++; if (halted !== 1'b0 || busy_regs !== 16'h0) begin n_fail++; $display("FAIL halt_wb got=%0b/%h exp=0/0000", halted, busy_regs); end
    tick();
    n_tests++; if (halted !== 1'b1 || dec_ready !== 1'b0) begin n_fail++; $display("FAIL halt_done got=%0b/%0b exp=1/0", halted, dec_ready); end
    repeat (2) tick();
    n_tests++; if (halted !== 1'b1) begin n_fail++; $display("FAIL halt_sticky got=%0b exp=1", halted); end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    #1;
    n_tests++; if (halted !== 1'b0 || dec_ready !== 1'b1) begin n_fail++; $display("FAIL halt_flush_exit got=%0b/%0b exp=0/1", halted, dec_ready); end
    set_dec(1'b0, 8'h00, 2'd0, 16'd0, 2'd0, 16'd0, 1'b0);
    tick();
  endtask

  task automatic test_flush();
    set_dec(1'b1, 8'h50, 2'd1, 16'd4, 2'd0, 16'd0, 1'b1);
    tick();
    set_dec(1'b1, 8'h51, 2'd1, 16'd5, 2'd0, 16'd0, 1'b1);
    tick();
    ex_ready = 1'b0;
    set_dec(1'b1, 8'h52, 2'd3, 16'd4, 2'd0, 16'd0, 1'b0);
    tick();
    n_tests++; if (busy_regs !== 16'h0030 || ex_valid !== 1'b1) begin n_fail++; $display("FAIL fl_setup got=%h/%0b exp=0030/1", busy_regs, ex_valid); end
    flush = 1'b1; wb_valid = 1'b1; wb_reg = 4'd4; ex_ready = 1'b1;
    #1;
    n_tests++; if (dec_ready !== 1'b0) begin n_fail++; $display("FAIL fl_ready got=%0b exp=0", dec_ready); end
    tick();
    flush = 1'b0; wb_valid = 1'b0;
    #1;
    n_tests++; if (busy_regs !== 16'h0 || ex_valid !== 1'b0 || halted !== 1'b0 || dec_ready !== 1'b1)
      begin n_fail++; $display("FAIL fl_after got=%h/%0b/%0b/%0b exp=0000/0/0/1", busy_regs, ex_valid, halted, dec_ready); end
    set_dec(1'b0, 8'h00, 2'd0, 16'd0, 2'd0, 16'd0, 1'b0);
    tick();
  endtask

  task automatic test_random();
    logic [7:0] opc;
    int r;
    rst_n = 1'b0; flush = 1'b0; wb_valid = 1'b0;
    set_dec(1'b0, 8'h00, 2'd0, 16'd0, 2'd0, 16'd0, 1'b0);
    repeat (2) tick();
    rst_n = 1'b1;
    m_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      r = int'($urandom_range(0, 99));
      opc = (r < 10) ? 8'h00 : (r < 13) ? 8'hFF : 8'($urandom_range(1, 254));
      if (opc == 8'hFF)
        set_dec(1'b1, opc, 2'd0, 16'($urandom), 2'd2, 16'($urandom), 1'b0);
      else
        set_dec($urandom_range(0, 9) < 7, opc, 2'($urandom),
                {12'($urandom), 4'($urandom_range(0, 7))}, 2'($urandom),
                {12'($urandom), 4'($urandom_range(0, 7))}, 1'($urandom));
      ex_ready = $urandom_range(0, 3) != 0;
      wb_valid = $urandom_range(0, 1) == 1;
      wb_reg   = 4'($urandom_range(0, 7));
      flush    = m_halted ? ($urandom_range(0, 4) == 0) : ($urandom_range(0, 99) == 0);
      #1;
      n_tests++; if (dec_ready !== m_ready()) begin n_fail++; $display("FAIL rnd_ready cyc=%0d got=%0b exp=%0b", cyc, dec_ready, m_ready()); end
      n_tests++; if (ex_valid !== m_exv) begin n_fail++; $display("FAIL rnd_ex_valid cyc=%0d got=%0b exp=%0b", cyc, ex_valid, m_exv); end
      n_tests++; if (busy_regs !== m_busy_vec()) begin n_fail++; $display("FAIL rnd_busy cyc=%0d got=%h exp=%h", cyc, busy_regs, m_busy_vec()); end
      n_tests++; if (halted !== m_halted) begin n_fail++; $display("FAIL rnd_halted cyc=%0d got=%0b exp=%0b", cyc, halted, m_halted); end
      if (m_exv) begin
        n_tests++;
        if (ex_opcode !== m_opc || ex_mode1 !== m_m1 || ex_op1 !== m_o1 || ex_mode2 !== m_m2 || ex_op2 !== m_o2) begin
          n_fail++;
          $display("FAIL rnd_payload cyc=%0d got=%h/%0d/%h/%0d/%h exp=%h/%0d/%h/%0d/%h", cyc,
                   ex_opcode, ex_mode1, ex_op1, ex_mode2, ex_op2, m_opc, m_m1, m_o1, m_m2, m_o2);
        end
      end
      m_step();
      tick();
    end
    flush = 1'b0; wb_valid = 1'b0;
    set_dec(1'b0, 8'h00, 2'd0, 16'd0, 2'd0, 16'd0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_raw_stall();
    test_backpressure();
    test_same_cycle();
    test_halt_drain();
    test_flush();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
